// File: rtl/mult_sequencer.sv
// Control sequencer for the signed shift-add multiplier: converts Run / Load levels into
// single-cycle datapath strobes. Define MULT_FIXED_LATENCY_EN for data-independent latency.
module mult_sequencer #(
    parameter int N_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load_b_req,
    input  logic m,
    output logic clr_xa,
    output logic ld_b,
    output logic add,
    output logic sub,
    output logic shift,
    output logic busy,
    output logic done
);

    localparam int IW = (N_BITS > 2) ? $clog2(N_BITS) : 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(N_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADB = 3'd1,
        S_CLRXA = 3'd2,
        S_EVAL  = 3'd3,
        S_SHIFT = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            run_q, ldb_q;
    logic            run_rise, ldb_rise, last_iter;

    assign run_rise  = run & ~run_q;
    assign ldb_rise  = load_b_req & ~ldb_q;
    assign last_iter = (iter_q == LAST_ITER);

    // Next-state and iteration counter
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: begin
                // Load wins over a coincident run edge; that run edge is lost
                if (ldb_rise) begin
                    state_d = S_LOADB;
                end else if (run_rise) begin
                    state_d = S_CLRXA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOADB: state_d = S_IDLE;
            S_CLRXA: begin
                iter_d  = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
`ifdef MULT_FIXED_LATENCY_EN
                state_d = S_SHIFT;
`else
                if (m) begin
                    state_d = S_SHIFT;
                end else if (last_iter) begin
                    state_d = S_HOLD;
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = S_EVAL;
                end
`endif
            end
            S_SHIFT: begin
                if (last_iter) begin
                    state_d = S_HOLD;
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = S_EVAL;
                end
            end
            S_HOLD: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; edge-detect history resets high so a held button never fires
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            run_q   <= 1'b1;
            ldb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            run_q   <= run;
            ldb_q   <= load_b_req;
        end
    end

    // Strobe decode from state (add/sub also use m, which is itself a register output)
    always_comb begin
        clr_xa = 1'b0;
        ld_b   = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        shift  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOADB: begin
                ld_b   = 1'b1;
                clr_xa = 1'b1;
            end
            S_CLRXA: begin
                clr_xa = 1'b1;
                busy   = 1'b1;
            end
            S_EVAL: begin
                busy = 1'b1;
                add  = m & ~last_iter;
                sub  = m & last_iter;
`ifndef MULT_FIXED_LATENCY_EN
                shift = ~m;
`endif
            end
            S_SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
            end
            S_HOLD: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed vectors driving a small X:A:B datapath model.
module tb_mult_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic load_b_req = 1'b0;
    logic m;
    logic clr_xa, ld_b, add, sub, shift, busy, done;

    int checks = 0;
    int failures = 0;

    // Datapath model: S from switches, X:A accumulator, B multiplier
    logic [7:0] sw  = 8'h00;
    logic       x_m = 1'b0;
    logic [7:0] a_m = 8'h00;
    logic [7:0] b_m = 8'h00;

    assign m = b_m[0];

    mult_sequencer #(.N_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .load_b_req (load_b_req),
        .m          (m),
        .clr_xa     (clr_xa),
        .ld_b       (ld_b),
        .add        (add),
        .sub        (sub),
        .shift      (shift),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_xa) begin
            x_m <= 1'b0;
            a_m <= 8'h00;
        end else if (add) begin
            {x_m, a_m} <= {a_m[7], a_m} + {sw[7], sw};
        end else if (sub) begin
            {x_m, a_m} <= {a_m[7], a_m} - {sw[7], sw};
        end else if (shift) begin
            a_m <= {x_m, a_m[7:1]};
            b_m <= {a_m[0], b_m[7:1]};
        end
        if (ld_b) b_m <= sw;
    end

    typedef struct {
        logic [7:0]  s;
        logic [7:0]  b;
        int          adds;
        int          subs;
        int          done_def;
        int          done_fix;
        logic [15:0] prod;
        bit          disturb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {clr_xa, ld_b, add, sub, shift, busy, done};
    endfunction

    task automatic load_b(input logic [7:0] val);
        sw = val;
        @(negedge clk) load_b_req = 1'b1;
        @(negedge clk);
        load_b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_mult(input int idx);
        vec_t v;
        int   done_at, n_add, n_sub, n_shift, mutex_bad, ldb_seen, not_busy, exp_done;
        v = vecs[idx];
        done_at = 0; n_add = 0; n_sub = 0; n_shift = 0;
        mutex_bad = 0; ldb_seen = 0; not_busy = 0;
`ifdef MULT_FIXED_LATENCY_EN
        exp_done = v.done_fix;
`else
        exp_done = v.done_def;
`endif
        load_b(v.b);
        sw = v.s;
        @(negedge clk) run = 1'b1;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            @(negedge clk);
            if (c == 1) chk($sformatf("v%0d_clrxa_c1", idx), {30'd0, clr_xa, busy}, 32'd3);
            if ((add && sub) || ((add || sub) && shift)) mutex_bad++;
            if (ld_b) ldb_seen++;
            n_add   += int'(add);
            n_sub   += int'(sub);
            n_shift += int'(shift);
            if (done) done_at = c;
            else if (!busy) not_busy++;
            if (v.disturb && c == 4) begin
                load_b_req = 1'b1;
                run = 1'b0;
            end
            if (v.disturb && c == 6) load_b_req = 1'b0;
        end
        chk($sformatf("v%0d_done_cycle", idx), done_at, exp_done);
        chk($sformatf("v%0d_adds", idx), n_add, v.adds);
        chk($sformatf("v%0d_subs", idx), n_sub, v.subs);
        chk($sformatf("v%0d_shifts", idx), n_shift, 32'd8);
        chk($sformatf("v%0d_mutex", idx), mutex_bad, 32'd0);
        chk($sformatf("v%0d_ldb_ignored", idx), ldb_seen, 32'd0);
        chk($sformatf("v%0d_busy", idx), not_busy, 32'd0);
        chk($sformatf("v%0d_product", idx), {16'd0, a_m, b_m}, {16'd0, v.prod});
        if (!v.disturb) begin
            // Held run must keep the result and never restart
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_hold", idx), {25'd0, outs()}, 32'h01);
            run = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d_back_idle", idx), {25'd0, outs()}, 32'h00);
    endtask

    initial begin
        //           s      b      adds subs def fix prod      disturb
        vecs[0] = '{8'h03, 8'h81, 1, 1, 12, 18, 16'hFE83, 1'b0};
        vecs[1] = '{8'h05, 8'h00, 0, 0, 10, 18, 16'h0000, 1'b0};
        vecs[2] = '{8'h07, 8'hFF, 7, 1, 18, 18, 16'hFFF9, 1'b0};
        vecs[3] = '{8'h80, 8'h7F, 7, 0, 17, 18, 16'hC080, 1'b1};
        vecs[4] = '{8'hFD, 8'hFE, 6, 1, 17, 18, 16'h0006, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 0, 1, 11, 18, 16'h4000, 1'b0};

        // Reset with buttons held: nothing may fire after release
        run = 1'b1;
        load_b_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {25'd0, outs()}, 32'h00);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("held_after_reset_%0d", c), {25'd0, outs()}, 32'h00);
        end
        run = 1'b0;
        load_b_req = 1'b0;
        @(negedge clk);

        // Load B: one ld_b+clr_xa cycle, no repeat while held
        sw = 8'h81;
        @(negedge clk) load_b_req = 1'b1;
        @(negedge clk);
        chk("loadb_pulse", {25'd0, outs()}, 32'h60);
        @(negedge clk);
        chk("loadb_back_idle", {25'd0, outs()}, 32'h00);
        repeat (3) @(negedge clk);
        chk("loadb_no_repeat", {25'd0, outs()}, 32'h00);
        chk("loadb_model_b", {24'd0, b_m}, 32'h81);
        load_b_req = 1'b0;
        @(negedge clk);

        // Simultaneous load and run edges: load wins, run edge discarded
        @(negedge clk) begin
            load_b_req = 1'b1;
            run = 1'b1;
        end
        @(negedge clk);
        chk("simul_loadb", {25'd0, outs()}, 32'h60);
        @(negedge clk);
        @(negedge clk);
        chk("simul_run_dropped", {25'd0, outs()}, 32'h00);
        load_b_req = 1'b0;
        run = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_mult(i);

        // Reset in the middle of a B=0xFF multiply, then restart from IDLE
        load_b(8'hFF);
        sw = 8'h07;
        @(negedge clk) run = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {25'd0, outs()}, 32'h00);
        reset = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("midreset_idle", {25'd0, outs()}, 32'h00);
        run_mult(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Control sequencer for the 8-bit signed shift-add multiplier datapath: XA accumulator (X sign bit plus A), B multiplier register, and 9-bit add/sub unit.
- Turns the synchronized Run and Reset/Load/Clear button levels into single-cycle clr_xa / ld_b / add / sub / shift strobes.
- Steps N_BITS iterations. Iterations 0..N_BITS-2 add when m=1; the final iteration subtracts when m=1.
- Sits between the sync_debounce outputs and the register/adder instances in the lab top level.

Parameters:
- N_BITS, 8, multiplier width = number of iterations; legal range 2..16; iteration counter width is $clog2(N_BITS).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; forces IDLE
- run  input  1  synchronized Run button level, active-high
- load_b_req  input  1  synchronized Reset/Load/Clear level, active-high
- m  input  1  current B[0] from the B register
- clr_xa  output  1  clear X and A registers this cycle
- ld_b  output  1  load B from switches this cycle
- add  output  1  datapath computes XA+S and loads it into XA this cycle
- sub  output  1  datapath computes XA-S and loads it into XA this cycle
- shift  output  1  arithmetic right shift of X:A:B by one this cycle
- busy  output  1  high while a multiply is in progress
- done  output  1  high while the result is held (HOLD state)

Behaviour:
- Reset: state=IDLE, iter=0, run_q=1, ldb_q=1. All outputs 0.
  - run_q/ldb_q reset to 1 so a button held through reset never fires.
- Edge detect: run_rise = run & ~run_q; ldb_rise = load_b_req & ~ldb_q. run_q/ldb_q are registered every cycle.
- States: IDLE, LOADB, CLRXA, EVAL, SHIFT, HOLD.
- IDLE:
  - ldb_rise → LOADB.
  - Else run_rise → CLRXA.
  - ldb_rise has priority; a simultaneous run_rise is discarded.
- LOADB: ld_b=1 and clr_xa=1 for exactly one cycle → IDLE.
- CLRXA: clr_xa=1, iter←0 → EVAL.
- EVAL, m=1:
  - add=1 if iter<N_BITS-1; sub=1 if iter==N_BITS-1.
  - → SHIFT.
- EVAL, m=0 (default build): shift=1 in the same cycle, no add/sub.
  - iter==N_BITS-1 → HOLD; else iter←iter+1, stay EVAL.
- SHIFT: shift=1.
  - iter==N_BITS-1 → HOLD; else iter←iter+1 → EVAL.
- HOLD: done=1, all strobes 0.
  - run==0 → IDLE. A held run never restarts a multiply.
- Output decode:
  - busy=1 in CLRXA, EVAL, SHIFT.
  - add/sub are decoded from state and m (m is a register output, glitch-free).
  - All other outputs are decoded from state only.
- Mutual exclusion: add, sub and shift are never high in the same cycle except shift with add=sub=0. add and sub are never both high.
- Latency, run_rise sampled at edge 0:
  - CLRXA occupies cycle 1; first EVAL is cycle 2.
  - Default build: HOLD entered at cycle 2+N_BITS+popcount(B).
- Ignored during busy: ldb_rise and run falling are both ignored; the multiply always completes.
- Back-to-back: a new multiply requires run low (HOLD→IDLE) and then a new rising edge.
  - Each run clears XA, so repeated runs use the current B, not the previous product.
- Reset asserted in any state: next cycle IDLE, all outputs 0, iter=0. Partial results in the datapath are left to the datapath's own reset.

Optional Feature:
- Macro: MULT_FIXED_LATENCY_EN.
- Defined: EVAL always → SHIFT; with m=0, EVAL asserts no strobes. Every multiply takes exactly 2*N_BITS EVAL/SHIFT cycles, so HOLD is entered at cycle 2+2*N_BITS.
- Undefined: the data-dependent merged-shift behaviour above.

Test Plan:
- Reset with run=1 held, release reset → stays IDLE; zero strobes for 20 cycles.
- load_b_req rising in IDLE → one cycle with ld_b=1 and clr_xa=1, then IDLE; holding load_b_req high produces no repeat.
- Default build, bench B-model = 0x81, run rise → clr_xa at cycle 1; add once (iter 0); sub once (iter 7); 8 shifts; done first high at cycle 12; product XA:B = 0x0000 after a datapath with S=0 or matches the signed model.
- Default build, B=0x00 → 8 consecutive shift-only cycles (2..9); done at cycle 10; add/sub never asserted.
- MULT_FIXED_LATENCY_EN, B=0xFF → 7 add pulses, 1 sub pulse, 8 shifts, done at cycle 18; B=0x00 → also done at cycle 18.
- Reset asserted at cycle 6 of a B=0xFF multiply → IDLE next cycle, outputs 0; next run rise restarts with clr_xa, and the full sequence matches the run-from-IDLE trace.
